// File: rtl/acorn_pkg.sv
// Purpose: shared phase encoding and step-count constants for the ACORN-128 phase sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acorn_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_INIT,
    PH_AD,
    PH_AD_PAD,
    PH_ENC,
    PH_ENC_PAD,
    PH_FINAL,
    PH_DONE
  } phase_e;

  localparam int INIT_STEPS   = 1792;
  localparam int PAD_STEPS    = 256;
  localparam int PAD_CA_STEPS = 128;
  localparam int FINAL_STEPS  = 768;
  localparam int TAG_START    = 640;

endpackage

// File: rtl/acorn_phase_sequencer_if.sv
// Purpose: bit-serial AD/PT input streams, CT output stream and state-core control bundle.
// Latency: n/a (wiring only).
// Backpressure: ad_ready/pt_ready from the sequencer gate consumption of ad_bit/pt_bit.
// Ports: master = stream source / core side, slave = the sequencer.
interface acorn_phase_sequencer_if;
  logic ad_bit;
  logic ad_valid;
  logic ad_ready;
  logic pt_bit;
  logic pt_valid;
  logic pt_ready;
  logic ct_bit;
  logic ct_valid;
  logic ks_in;
  logic step_en;
  logic ca;
  logic cb;
  logic mbit;

  modport master (
    output ad_bit, ad_valid, pt_bit, pt_valid, ks_in,
    input  ad_ready, pt_ready, ct_bit, ct_valid, step_en, ca, cb, mbit
  );

  modport slave (
    input  ad_bit, ad_valid, pt_bit, pt_valid, ks_in,
    output ad_ready, pt_ready, ct_bit, ct_valid, step_en, ca, cb, mbit
  );
endinterface

// File: rtl/acorn_init_mbit.sv
// Purpose: message bit fed to the core during initialization, selected from key/IV by step index.
// Latency: combinational.
// Backpressure: none.
// Ports: cnt (11-bit init step), key, iv in; mbit out.
module acorn_init_mbit (
  input  logic [10:0]  cnt,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  output logic         mbit
);

  // Steps 0..127 load the key, 128..255 the IV, then the key repeats for the rest
  // of the 1792 steps with step 256 (key bit 0) inverted as the domain separator.
  always_comb begin
    mbit = key[cnt[6:0]];
    if (cnt < 11'd128) begin
      mbit = key[cnt[6:0]];
    end else if (cnt < 11'd256) begin
      mbit = iv[cnt[6:0]];
    end else if (cnt == 11'd256) begin
      mbit = ~key[0];
    end
  end

endmodule

// File: rtl/acorn_phase_sequencer.sv
// Purpose: sequences ACORN-128 init/AD/pad/encrypt/pad/final phases, drives core controls, captures tag.
// Latency: controls are combinational from registered phase/counter; done one cycle after last step.
// Backpressure: AD/ENC steps only when ad_valid/pt_valid; ready is held high for the whole phase.
// Ports: clk/rst; start + key/iv/lengths; bus (streams + core controls); busy, done, tag_out.
module acorn_phase_sequencer
  import acorn_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [127:0]         key_in,
  input  logic [127:0]         iv_in,
  input  logic [LEN_W-1:0]     ad_len,
  input  logic [LEN_W-1:0]     pt_len,
  acorn_phase_sequencer_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [127:0]         tag_out
);

  localparam logic [LEN_W-1:0] INIT_LAST  = LEN_W'(INIT_STEPS - 1);
  localparam logic [LEN_W-1:0] PAD_LAST   = LEN_W'(PAD_STEPS - 1);
  localparam logic [LEN_W-1:0] PAD_CA_END = LEN_W'(PAD_CA_STEPS);
  localparam logic [LEN_W-1:0] FINAL_LAST = LEN_W'(FINAL_STEPS - 1);
  localparam logic [LEN_W-1:0] TAG_FIRST  = LEN_W'(TAG_START);

  phase_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       iv_q, iv_d;
  logic [LEN_W-1:0]   ad_len_q, ad_len_d;
  logic [LEN_W-1:0]   pt_len_q, pt_len_d;
  logic [127:0]       tag_q, tag_d;
  logic               done_q, done_d;

  logic init_mbit;
  logic step_en_c, ca_c, cb_c, mbit_c;
  logic ad_ready_c, pt_ready_c, ct_bit_c, ct_valid_c;

  acorn_init_mbit u_init_mbit (
    .cnt  (cnt_q[10:0]),
    .key  (key_q),
    .iv   (iv_q),
    .mbit (init_mbit)
  );

  // Core controls decoded from the current phase and step index.
  always_comb begin
    step_en_c  = 1'b0;
    ca_c       = 1'b0;
    cb_c       = 1'b0;
    mbit_c     = 1'b0;
    ad_ready_c = 1'b0;
    pt_ready_c = 1'b0;
    ct_bit_c   = 1'b0;
    ct_valid_c = 1'b0;
    case (state_q)
      PH_INIT: begin
        step_en_c = 1'b1;
        ca_c      = 1'b1;
        cb_c      = 1'b1;
        mbit_c    = init_mbit;
      end
      PH_AD: begin
        ad_ready_c = 1'b1;
        step_en_c  = bus.ad_valid;
        mbit_c     = bus.ad_bit;
        ca_c       = 1'b1;
        cb_c       = 1'b1;
      end
      PH_AD_PAD: begin
        step_en_c = 1'b1;
        mbit_c    = (cnt_q == '0);
        ca_c      = (cnt_q < PAD_CA_END);
        cb_c      = 1'b1;
      end
      PH_ENC: begin
        pt_ready_c = 1'b1;
        step_en_c  = bus.pt_valid;
        mbit_c     = bus.pt_bit;
        ca_c       = 1'b1;
        ct_bit_c   = bus.pt_bit ^ bus.ks_in;
        ct_valid_c = bus.pt_valid;
      end
      PH_ENC_PAD: begin
        step_en_c = 1'b1;
        mbit_c    = (cnt_q == '0);
        ca_c      = (cnt_q < PAD_CA_END);
      end
      PH_FINAL: begin
        step_en_c = 1'b1;
        ca_c      = 1'b1;
        cb_c      = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase/counter advance; the counter restarts at zero on every phase change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    iv_d     = iv_q;
    ad_len_d = ad_len_q;
    pt_len_d = pt_len_q;
    tag_d    = tag_q;
    done_d   = 1'b0;
    case (state_q)
      PH_IDLE, PH_DONE: begin
        if (start) begin
          state_d  = PH_INIT;
          cnt_d    = '0;
          key_d    = key_in;
          iv_d     = iv_in;
          ad_len_d = ad_len;
          pt_len_d = pt_len;
        end
      end
      PH_INIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = (ad_len_q == '0) ? PH_AD_PAD : PH_AD;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      PH_AD: begin
        if (bus.ad_valid) begin
          if (cnt_q + LEN_W'(1) == ad_len_q) begin
            cnt_d   = '0;
            state_d = PH_AD_PAD;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      PH_AD_PAD: begin
        if (cnt_q == PAD_LAST) begin
          cnt_d   = '0;
          state_d = (pt_len_q == '0) ? PH_ENC_PAD : PH_ENC;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      PH_ENC: begin
        if (bus.pt_valid) begin
          if (cnt_q + LEN_W'(1) == pt_len_q) begin
            cnt_d   = '0;
            state_d = PH_ENC_PAD;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      PH_ENC_PAD: begin
        if (cnt_q == PAD_LAST) begin
          cnt_d   = '0;
          state_d = PH_FINAL;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      PH_FINAL: begin
        // The last 128 finalization steps expose tag bits 0..127 on ks_in;
        // TAG_START is a multiple of 128 so the low counter bits index the tag.
        if (cnt_q >= TAG_FIRST) begin
          tag_d[cnt_q[6:0]] = bus.ks_in;
        end
        if (cnt_q == FINAL_LAST) begin
          cnt_d   = '0;
          state_d = PH_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = PH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PH_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      ad_len_q <= '0;
      pt_len_q <= '0;
      tag_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      ad_len_q <= ad_len_d;
      pt_len_q <= pt_len_d;
      tag_q    <= tag_d;
      done_q   <= done_d;
    end
  end

  assign bus.step_en  = step_en_c;
  assign bus.ca       = ca_c;
  assign bus.cb       = cb_c;
  assign bus.mbit     = mbit_c;
  assign bus.ad_ready = ad_ready_c;
  assign bus.pt_ready = pt_ready_c;
  assign bus.ct_bit   = ct_bit_c;
  assign bus.ct_valid = ct_valid_c;

  assign busy    = (state_q != PH_IDLE) && (state_q != PH_DONE);
  assign done    = done_q;
  assign tag_out = tag_q;

endmodule

// File: tb/tb_acorn_phase_sequencer.sv
// Purpose: directed self-checking bench for acorn_phase_sequencer.
// Latency: n/a.
// Backpressure: exercises AD stalls via a toggling ad_valid.
module tb_acorn_phase_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] iv_in;
  logic [15:0]  ad_len;
  logic [15:0]  pt_len;
  logic         busy;
  logic         done;
  logic [127:0] tag_out;

  acorn_phase_sequencer_if bus_if ();

  acorn_phase_sequencer #(.LEN_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_in  (key_in),
    .iv_in   (iv_in),
    .ad_len  (ad_len),
    .pt_len  (pt_len),
    .bus     (bus_if),
    .busy    (busy),
    .done    (done),
    .tag_out (tag_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller in the first INIT cycle, 1 time unit after the edge.
  task automatic start_op(input logic [127:0] k, input logic [127:0] v,
                          input logic [15:0] al, input logic [15:0] pl);
    tick();
    start  = 1'b1;
    key_in = k;
    iv_in  = v;
    ad_len = al;
    pt_len = pl;
    tick();
    start  = 1'b0;
  endtask

  logic [127:0] ones;
  logic         exp_m;
  int           steps;
  int           bad_init, bad_pad, bad_fin, bad_rdy, bad_busy, bad_ad, ad_steps;
  logic [3:0]   pt_seq;
  logic [3:0]   ct_exp;

  initial begin
    ones = '1;
    rst = 1'b1; start = 1'b0; key_in = '0; iv_in = '0; ad_len = '0; pt_len = '0;
    bus_if.ad_bit = 1'b0; bus_if.ad_valid = 1'b0;
    bus_if.pt_bit = 1'b0; bus_if.pt_valid = 1'b0; bus_if.ks_in = 1'b0;
    tick(); tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_step_en", bus_if.step_en, 1'b0);
    chkv("rst_tag", tag_out, 128'h0);
    rst = 1'b0;
    tick();
    bus_if.ad_valid = 1'b1; bus_if.pt_valid = 1'b1;
    #1;
    chk1("idle_ad_ready", bus_if.ad_ready, 1'b0);
    chk1("idle_pt_ready", bus_if.pt_ready, 1'b0);
    chk1("idle_step_en", bus_if.step_en, 1'b0);

    // Run A: no AD/PT, key=1, iv=ones; ks high only in FINAL steps 640..767.
    start_op(128'h1, ones, 16'd0, 16'd0);
    steps = 0; bad_init = 0; bad_pad = 0; bad_fin = 0; bad_rdy = 0; bad_busy = 0;
    for (int k = 0; k < 3072; k++) begin
      if (k > 0) tick();
      bus_if.ks_in = (k >= 2304 + 640);
      #1;
      if (bus_if.step_en === 1'b1) steps++;
      if (bus_if.ad_ready !== 1'b0 || bus_if.pt_ready !== 1'b0 || bus_if.ct_valid !== 1'b0) bad_rdy++;
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (k < 1792) begin
        if (k < 128)       exp_m = (k == 0);
        else if (k < 256)  exp_m = 1'b1;
        else if (k == 256) exp_m = 1'b0;
        else               exp_m = ((k % 128) == 0);
        if (bus_if.mbit !== exp_m || bus_if.ca !== 1'b1 || bus_if.cb !== 1'b1) bad_init++;
      end else if (k < 2048) begin
        if (bus_if.mbit !== (k == 1792) || bus_if.ca !== (k < 1920) || bus_if.cb !== 1'b1) bad_pad++;
      end else if (k < 2304) begin
        if (bus_if.mbit !== (k == 2048) || bus_if.ca !== (k < 2176) || bus_if.cb !== 1'b0) bad_pad++;
      end else begin
        if (bus_if.mbit !== 1'b0 || bus_if.ca !== 1'b1 || bus_if.cb !== 1'b1) bad_fin++;
      end
      if (k == 0)    chk1("init_m0", bus_if.mbit, 1'b1);
      if (k == 1)    chk1("init_m1", bus_if.mbit, 1'b0);
      if (k == 127)  chk1("init_m127", bus_if.mbit, 1'b0);
      if (k == 128)  chk1("init_m128", bus_if.mbit, 1'b1);
      if (k == 255)  chk1("init_m255", bus_if.mbit, 1'b1);
      if (k == 256)  chk1("init_m256", bus_if.mbit, 1'b0);
      if (k == 257)  chk1("init_m257", bus_if.mbit, 1'b0);
      if (k == 384)  chk1("init_m384", bus_if.mbit, 1'b1);
      if (k == 1792) chk1("adpad_m0", bus_if.mbit, 1'b1);
      if (k == 1919) chk1("adpad_ca127", bus_if.ca, 1'b1);
      if (k == 1920) chk1("adpad_ca128", bus_if.ca, 1'b0);
      if (k == 2048) chk1("encpad_cb", bus_if.cb, 1'b0);
      if (k == 2175) chk1("encpad_ca127", bus_if.ca, 1'b1);
      if (k == 2176) chk1("encpad_ca128", bus_if.ca, 1'b0);
    end
    chkv("a_steps", 128'(steps), 128'd3072);
    chkv("a_init_mbit_errs", 128'(bad_init), 128'd0);
    chkv("a_pad_errs", 128'(bad_pad), 128'd0);
    chkv("a_final_errs", 128'(bad_fin), 128'd0);
    chkv("a_ready_errs", 128'(bad_rdy), 128'd0);
    chkv("a_busy_errs", 128'(bad_busy), 128'd0);
    tick();
    bus_if.ks_in = 1'b0;
    #1;
    chk1("a_done", done, 1'b1);
    chk1("a_busy_done", busy, 1'b0);
    chk1("a_step_done", bus_if.step_en, 1'b0);
    chkv("a_tag", tag_out, ones);
    tick();
    chk1("a_done_drop", done, 1'b0);
    chkv("a_tag_held", tag_out, ones);

    // Run B: ad_len=8 with toggling valid, pt_len=4, tag bit 0 only.
    bus_if.ad_valid = 1'b0; bus_if.pt_valid = 1'b0;
    start_op(128'h0, 128'h0, 16'd8, 16'd4);
    steps = 0; bad_ad = 0; ad_steps = 0;
    for (int k = 0; k < 1792; k++) begin
      if (k > 0) tick();
      if (bus_if.step_en === 1'b1) steps++;
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      bus_if.ad_valid = ((i % 2) == 0);
      bus_if.ad_bit   = 1'((i >> 1) & 1);
      #1;
      if (bus_if.step_en === 1'b1) begin steps++; ad_steps++; end
      if (bus_if.step_en !== bus_if.ad_valid || bus_if.ad_ready !== 1'b1) bad_ad++;
      if (bus_if.mbit !== bus_if.ad_bit || bus_if.ca !== 1'b1 || bus_if.cb !== 1'b1) bad_ad++;
    end
    chkv("b_ad_steps", 128'(ad_steps), 128'd8);
    chkv("b_ad_errs", 128'(bad_ad), 128'd0);
    tick();
    bus_if.ad_valid = 1'b0;
    #1;
    chk1("b_adpad_ready", bus_if.ad_ready, 1'b0);
    chk1("b_adpad_step", bus_if.step_en, 1'b1);
    chk1("b_adpad_mbit", bus_if.mbit, 1'b1);
    if (bus_if.step_en === 1'b1) steps++;
    for (int k = 1; k < 256; k++) begin
      tick();
      if (bus_if.step_en === 1'b1) steps++;
    end
    pt_seq = 4'b1101;  // bit j = plaintext bit j: 1,0,1,1
    ct_exp = 4'b0010;  // with ks=1: 0,1,0,0
    for (int j = 0; j < 4; j++) begin
      tick();
      bus_if.pt_valid = 1'b1;
      bus_if.pt_bit   = pt_seq[j];
      bus_if.ks_in    = 1'b1;
      start           = (j == 0);
      #1;
      if (bus_if.step_en === 1'b1) steps++;
      chk1($sformatf("b_ct%0d", j), bus_if.ct_bit, ct_exp[j]);
      chk1($sformatf("b_ctv%0d", j), bus_if.ct_valid, 1'b1);
      chk1($sformatf("b_cb%0d", j), bus_if.cb, 1'b0);
      chk1($sformatf("b_ptrdy%0d", j), bus_if.pt_ready, 1'b1);
    end
    tick();
    start = 1'b0; bus_if.ks_in = 1'b0;
    #1;
    chk1("b_encpad_ptrdy", bus_if.pt_ready, 1'b0);
    chk1("b_encpad_ctv", bus_if.ct_valid, 1'b0);
    chk1("b_encpad_mbit", bus_if.mbit, 1'b1);
    chk1("b_encpad_cb", bus_if.cb, 1'b0);
    if (bus_if.step_en === 1'b1) steps++;
    bus_if.pt_valid = 1'b0;
    for (int k = 1; k < 256; k++) begin
      tick();
      if (bus_if.step_en === 1'b1) steps++;
    end
    for (int f = 0; f < 768; f++) begin
      tick();
      bus_if.ks_in = (f == 640);
      #1;
      if (bus_if.step_en === 1'b1) steps++;
    end
    tick();
    bus_if.ks_in = 1'b0;
    #1;
    chkv("b_steps", 128'(steps), 128'd3084);
    chk1("b_done", done, 1'b1);
    chkv("b_tag", tag_out, 128'h1);

    // Run C: restart from DONE, reset during INIT, then re-run INIT from zero.
    start_op(128'h1, ones, 16'd0, 16'd0);
    for (int k = 0; k <= 1000; k++) begin
      if (k > 0) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk1("c_rst_busy", busy, 1'b0);
    chk1("c_rst_step", bus_if.step_en, 1'b0);
    chkv("c_rst_tag", tag_out, 128'h0);
    start_op(128'h1, ones, 16'd0, 16'd0);
    #1;
    chk1("c_busy", busy, 1'b1);
    chk1("c_step", bus_if.step_en, 1'b1);
    chk1("c_m0", bus_if.mbit, 1'b1);
    tick();
    chk1("c_m1", bus_if.mbit, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
